fft_bitrev_reorder: RTL and testbench

//  Consumer end of the SDF FFT output stream. It accepts one complex sample per enabled cycle,
//  in the bit-reversed order the SDF pipeline produces, and re-emits each N-point frame in

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_reorder_ram.sv | 23 ++
 rtl/fft_bitrev_reorder.sv | 139 +++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT helpers: log2, bit reversal and the default complex sample width.
package fft_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CPLX_W   = 2 * SAMPLE_W;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Reverses the low nbits of value; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r[i] = value[nbits - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle read latency).
module fft_reorder_ram #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed SDF FFT output frames into natural order via ping-pong banks.
// Output lags the last input of a frame by two cycles; back-to-back frames stream gaplessly.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_in_enable,
  input  logic [WIDTH-1:0]      data_in_real,
  input  logic [WIDTH-1:0]      data_in_imag,
  output logic                  data_out_enable,
  output logic [WIDTH-1:0]      data_out_real,
  output logic [WIDTH-1:0]      data_out_imag,
  output logic [log2(N)-1:0]    data_out_index,
  output logic                  data_out_last
);

  localparam int LOG_N = log2(N);
  localparam logic [LOG_N-1:0] LAST_ADDR = LOG_N'(N - 1);

  typedef enum logic {IDLE, READ} rd_state_t;

  logic [LOG_N-1:0]   wr_count;
  logic               wr_bank;
  logic [1:0]         full, full_n, full_set, full_now, full_clr;
  logic               wr_last;
  logic [31:0]        wr_rev;

  rd_state_t          state, state_n;
  logic [LOG_N-1:0]   rd_addr, rd_addr_n;
  logic               rd_bank, rd_bank_n;
  logic               rd_issue, rd_done;

  logic               rd_vld_d1;
  logic [LOG_N-1:0]   rd_idx_d1;
  logic [2*WIDTH-1:0] ram_rdata;

  assign wr_last  = data_in_enable && (wr_count == LAST_ADDR);
  assign wr_rev   = bitrev(32'(wr_count), LOG_N);
  assign full_set = wr_last ? (2'b01 << wr_bank) : 2'b00;
  // A bank completing on this very edge counts as full for the reader's decisions.
  assign full_now = full | full_set;
  assign full_clr = rd_done ? (2'b01 << rd_bank) : 2'b00;
  assign full_n   = full_now & ~full_clr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
      wr_bank  <= 1'b0;
      full     <= 2'b00;
    end else begin
      if (data_in_enable) begin
        wr_count <= wr_count + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      full <= full_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_addr <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_n;
      rd_addr <= rd_addr_n;
      rd_bank <= rd_bank_n;
    end
  end

  always_comb begin
    state_n   = state;
    rd_addr_n = rd_addr;
    rd_bank_n = rd_bank;
    rd_issue  = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (full_now[rd_bank]) begin
          state_n   = READ;
          rd_addr_n = '0;
        end
      end
      READ: begin
        rd_issue = 1'b1;
        if (rd_addr == LAST_ADDR) begin
          rd_done   = 1'b1;
          rd_bank_n = ~rd_bank;
          rd_addr_n = '0;
          if (!full_now[~rd_bank]) state_n = IDLE;
        end else begin
          rd_addr_n = rd_addr + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  fft_reorder_ram #(
    .DEPTH  (2 * N),
    .DATA_W (2 * WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (data_in_enable),
    .wr_addr ({wr_bank, wr_rev[LOG_N-1:0]}),
    .wr_data ({data_in_real, data_in_imag}),
    .rd_en   (rd_issue),
    .rd_addr ({rd_bank, rd_addr}),
    .rd_data (ram_rdata)
  );

  // Data and index hold between reads; only enable and last drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_vld_d1       <= 1'b0;
      rd_idx_d1       <= '0;
      data_out_enable <= 1'b0;
      data_out_real   <= '0;
      data_out_imag   <= '0;
      data_out_index  <= '0;
      data_out_last   <= 1'b0;
    end else begin
      rd_vld_d1       <= rd_issue;
      if (rd_issue) rd_idx_d1 <= rd_addr;
      data_out_enable <= rd_vld_d1;
      data_out_last   <= rd_vld_d1 && (rd_idx_d1 == LAST_ADDR);
      if (rd_vld_d1) begin
        data_out_real  <= ram_rdata[2*WIDTH-1:WIDTH];
        data_out_imag  <= ram_rdata[WIDTH-1:0];
        data_out_index <= rd_idx_d1;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder at N=8: expected natural-order samples are queued per frame.
module tb_fft_bitrev_reorder;

  localparam int N = 8;
  localparam int W = 16;

  logic         clock;
  logic         reset;
  logic         data_in_enable;
  logic [W-1:0] data_in_real;
  logic [W-1:0] data_in_imag;
  logic         data_out_enable;
  logic [W-1:0] data_out_real;
  logic [W-1:0] data_out_imag;
  logic [2:0]   data_out_index;
  logic         data_out_last;

  fft_bitrev_reorder #(.N(N), .WIDTH(W)) dut (
    .clock           (clock),
    .reset           (reset),
    .data_in_enable  (data_in_enable),
    .data_in_real    (data_in_real),
    .data_in_imag    (data_in_imag),
    .data_out_enable (data_out_enable),
    .data_out_real   (data_out_real),
    .data_out_imag   (data_out_imag),
    .data_out_index  (data_out_index),
    .data_out_last   (data_out_last)
  );

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [2:0]   idx;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_in_cyc = 0;
  int   seg_first = 0;
  int   seg_last = 0;
  int   seg_cnt = 0;
  int   overruns = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int br3(input int k);
    logic [2:0] v;
    v = 3'(k);
    return int'({v[0], v[1], v[2]});
  endfunction

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (data_in_enable) last_in_cyc = cyc;
    if (!reset && data_in_enable && dut.full[dut.wr_bank]) overruns++;
  end

  always @(negedge clock) begin
    if (!reset && data_out_enable) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 32'(data_out_index), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("real", 32'(data_out_real), 32'(e.re));
        chk("imag", 32'(data_out_imag), 32'(e.im));
        chk("index", 32'(data_out_index), 32'(e.idx));
        chk("last", 32'(data_out_last), 32'(e.idx == 3'd7));
      end
      if (seg_cnt == 0) seg_first = cyc;
      seg_last = cyc;
      seg_cnt++;
    end
  end

  // gap_mode: 0 contiguous, 1 alternating idle cycles, 2 random 0..2 idle cycles
  task automatic send_frame(input int base, input int gap_mode);
    for (int k = 0; k < N; k++) begin
      if (gap_mode == 1 && k > 0) @(negedge clock);
      if (gap_mode == 2) repeat ($urandom_range(0, 2)) @(negedge clock);
      data_in_enable = 1'b1;
      data_in_real   = W'(base + k);
      data_in_imag   = W'(-(base + k));
      @(negedge clock);
      data_in_enable = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.re  = W'(base + br3(i));
      e.im  = W'(-(base + br3(i)));
      e.idx = 3'(i);
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_en"},   32'(data_out_enable), 32'd0);
    chk({tag, "_re"},   32'(data_out_real),   32'd0);
    chk({tag, "_im"},   32'(data_out_imag),   32'd0);
    chk({tag, "_idx"},  32'(data_out_index),  32'd0);
    chk({tag, "_last"}, 32'(data_out_last),   32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    data_in_enable = 1'b0;
    data_in_real   = '0;
    data_in_imag   = '0;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset_init");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // single contiguous frame
    seg_cnt = 0;
    send_frame(0, 0);
    drain();
    chk("s1_count", 32'(seg_cnt), 32'd8);
    chk("s1_latency", 32'(seg_first - last_in_cyc), 32'd2);

    // three back-to-back frames must stream with no output gap
    seg_cnt = 0;
    send_frame(0, 0);
    send_frame(16, 0);
    send_frame(32, 0);
    drain();
    chk("s2_count", 32'(seg_cnt), 32'd24);
    chk("s2_gapless", 32'(seg_last - seg_first + 1), 32'd24);

    // alternating input gaps
    seg_cnt = 0;
    send_frame(0, 1);
    drain();
    chk("s3_count", 32'(seg_cnt), 32'd8);
    chk("s3_latency", 32'(seg_first - last_in_cyc), 32'd2);

    // partial frame discarded by an asynchronous reset
    seg_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      data_in_enable = 1'b1;
      data_in_real   = W'(200 + k);
      data_in_imag   = W'(300 + k);
      @(negedge clock);
    end
    data_in_enable = 1'b0;
    #2 reset = 1'b1;
    #1 check_outputs_zero("reset_async");
    repeat (2) @(negedge clock);
    check_outputs_zero("reset_hold");
    reset = 1'b0;
    @(negedge clock);
    send_frame(100, 0);
    drain();
    chk("s4_count", 32'(seg_cnt), 32'd8);

    // back-to-back frames with random input gaps
    seg_cnt = 0;
    send_frame(48, 2);
    send_frame(64, 2);
    send_frame(80, 2);
    drain();
    chk("s6_count", 32'(seg_cnt), 32'd24);
    chk("overrun", 32'(overruns), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
